// File: rtl/switch_allocator.sv
// Wormhole switch allocator for a 5-port router (L,N,E,S,W).
// Each output is locked from head to tail flit. Round-robin arbitration runs between packets.
module switch_allocator #(
   parameter logic [2:0] SEL_IDLE = 3'd7,
   parameter logic [2:0] RR_INIT  = 3'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Req_L,
   input  logic       Req_N,
   input  logic       Req_E,
   input  logic       Req_S,
   input  logic       Req_W,
   input  logic [2:0] Dest_L,
   input  logic [2:0] Dest_N,
   input  logic [2:0] Dest_E,
   input  logic [2:0] Dest_S,
   input  logic [2:0] Dest_W,
   input  logic       Tail_L,
   input  logic       Tail_N,
   input  logic       Tail_E,
   input  logic       Tail_S,
   input  logic       Tail_W,
   input  logic       Ready_L,
   input  logic       Ready_N,
   input  logic       Ready_E,
   input  logic       Ready_S,
   input  logic       Ready_W,
   output logic [2:0] Select_L,
   output logic [2:0] Select_N,
   output logic [2:0] Select_E,
   output logic [2:0] Select_S,
   output logic [2:0] Select_W,
   output logic       Grant_L,
   output logic       Grant_N,
   output logic       Grant_E,
   output logic       Grant_S,
   output logic       Grant_W
);

   typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

   logic [4:0] req_s, tail_s, ready_s;
   logic [2:0] dest_s [5];

   state_t     state_r  [5];
   logic [2:0] owner_r  [5];
   logic [2:0] ptr_r    [5];
   logic [2:0] select_r [5];

   logic [4:0] busy_s;
   logic [4:0] grant_s;
   logic [4:0] release_s;
   logic [4:0] any_req_s;
   logic [2:0] winner_s [5];

   // The result is (base + off) mod 5, for base and off in the range 0..4.
   function automatic logic [2:0] rr_index(input logic [2:0] base, input logic [2:0] off);
      logic [3:0] sum;
      sum = {1'b0, base} + {1'b0, off};
      if (sum >= 4'd5) begin
         rr_index = 3'(sum - 4'd5);
      end else begin
         rr_index = sum[2:0];
      end
   endfunction

   assign req_s   = {Req_W, Req_S, Req_E, Req_N, Req_L};
   assign tail_s  = {Tail_W, Tail_S, Tail_E, Tail_N, Tail_L};
   assign ready_s = {Ready_W, Ready_S, Ready_E, Ready_N, Ready_L};
   assign dest_s[0] = Dest_L;
   assign dest_s[1] = Dest_N;
   assign dest_s[2] = Dest_E;
   assign dest_s[3] = Dest_S;
   assign dest_s[4] = Dest_W;

   // Locked outputs: find which inputs own a lock, grant the owner's flits, and detect tail release.
   always_comb begin
      busy_s    = 5'b00000;
      grant_s   = 5'b00000;
      release_s = 5'b00000;
      for (int o = 0; o < 5; o++) begin
         if (state_r[o] == ST_LOCKED) begin
            busy_s[owner_r[o]] = 1'b1;
            if (req_s[owner_r[o]] && (dest_s[owner_r[o]] == 3'(o)) && ready_s[o]) begin
               grant_s[owner_r[o]] = 1'b1;
               release_s[o]        = tail_s[owner_r[o]];
            end else begin
               release_s[o] = 1'b0;
            end
         end else begin
            release_s[o] = 1'b0;
         end
      end
   end

   // Idle outputs: search for the first eligible requester, starting at ptr and wrapping.
   // An input that already owns a lock is not eligible.
   always_comb begin
      for (int o = 0; o < 5; o++) begin
         any_req_s[o] = 1'b0;
         winner_s[o]  = 3'd0;
         for (int k = 0; k < 5; k++) begin
            if (!any_req_s[o] && req_s[rr_index(ptr_r[o], 3'(k))] &&
                (dest_s[rr_index(ptr_r[o], 3'(k))] == 3'(o)) &&
                !busy_s[rr_index(ptr_r[o], 3'(k))]) begin
               any_req_s[o] = 1'b1;
               winner_s[o]  = rr_index(ptr_r[o], 3'(k));
            end else begin
               any_req_s[o] = any_req_s[o];
            end
         end
      end
   end

   // Per-output lock state machine, with a registered crossbar select.
   always_ff @(posedge clk) begin
      for (int o = 0; o < 5; o++) begin
         if (rst) begin
            state_r[o]  <= ST_IDLE;
            owner_r[o]  <= 3'd0;
            ptr_r[o]    <= RR_INIT;
            select_r[o] <= SEL_IDLE;
         end else begin
            case (state_r[o])
               ST_IDLE: begin
                  if (any_req_s[o]) begin
                     state_r[o]  <= ST_LOCKED;
                     owner_r[o]  <= winner_s[o];
                     select_r[o] <= winner_s[o];
                  end
               end
               ST_LOCKED: begin
                  if (release_s[o]) begin
                     state_r[o]  <= ST_IDLE;
                     ptr_r[o]    <= (owner_r[o] == 3'd4) ? 3'd0 : owner_r[o] + 3'd1;
                     select_r[o] <= SEL_IDLE;
                  end
               end
               default: begin
                  state_r[o]  <= ST_IDLE;
                  select_r[o] <= SEL_IDLE;
               end
            endcase
         end
      end
   end

   assign Select_L = select_r[0];
   assign Select_N = select_r[1];
   assign Select_E = select_r[2];
   assign Select_S = select_r[3];
   assign Select_W = select_r[4];
   assign {Grant_W, Grant_S, Grant_E, Grant_N, Grant_L} = grant_s;

endmodule

// File: tb/tb_switch_allocator.sv
// Randomized bench for switch_allocator. It checks the DUT against a port-level lock/round-robin model.
module tb_switch_allocator;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] req, tail, ready;
   logic [2:0] dest [5];
   wire  [4:0] gnt_w;
   wire  [2:0] sel_w [5];

   int n_vec = 0;
   int n_err = 0;

   // The reference model holds, for each output, a lock flag, the owning input and the round-robin start point.
   bit m_lock [5];
   int m_own  [5];
   int m_ptr  [5];
   logic [4:0] exp_gnt;
   int         exp_sel [5];
   int         rr_order [$];

   always #5 clk = ~clk;

   switch_allocator dut (
      .clk(clk), .rst(rst),
      .Req_L(req[0]), .Req_N(req[1]), .Req_E(req[2]), .Req_S(req[3]), .Req_W(req[4]),
      .Dest_L(dest[0]), .Dest_N(dest[1]), .Dest_E(dest[2]), .Dest_S(dest[3]), .Dest_W(dest[4]),
      .Tail_L(tail[0]), .Tail_N(tail[1]), .Tail_E(tail[2]), .Tail_S(tail[3]), .Tail_W(tail[4]),
      .Ready_L(ready[0]), .Ready_N(ready[1]), .Ready_E(ready[2]), .Ready_S(ready[3]), .Ready_W(ready[4]),
      .Select_L(sel_w[0]), .Select_N(sel_w[1]), .Select_E(sel_w[2]), .Select_S(sel_w[3]), .Select_W(sel_w[4]),
      .Grant_L(gnt_w[0]), .Grant_N(gnt_w[1]), .Grant_E(gnt_w[2]), .Grant_S(gnt_w[3]), .Grant_W(gnt_w[4])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int o = 0; o < 5; o++) begin
         m_lock[o] = 1'b0;
         m_own[o]  = 0;
         m_ptr[o]  = 0;
      end
   endtask

   // Compute the expected outputs for the current inputs from the current model state.
   task automatic model_outputs();
      exp_gnt = 5'b00000;
      for (int o = 0; o < 5; o++) begin
         exp_sel[o] = m_lock[o] ? m_own[o] : 7;
         if (m_lock[o] && req[m_own[o]] && dest[m_own[o]] == o && ready[o])
            exp_gnt[m_own[o]] = 1'b1;
      end
   endtask

   // Advance the model by one clock edge.
   task automatic model_step();
      bit owning [5];
      if (rst) begin
         model_reset();
      end else begin
         for (int i = 0; i < 5; i++) owning[i] = 1'b0;
         for (int o = 0; o < 5; o++) if (m_lock[o]) owning[m_own[o]] = 1'b1;
         for (int o = 0; o < 5; o++) begin
            if (m_lock[o]) begin
               if (exp_gnt[m_own[o]] && tail[m_own[o]]) begin
                  m_lock[o] = 1'b0;
                  m_ptr[o]  = (m_own[o] + 1) % 5;
               end
            end else begin
               int best = -1;
               int bestd = 99;
               for (int i = 0; i < 5; i++) begin
                  int d = (i - m_ptr[o] + 5) % 5;
                  if (req[i] && dest[i] == o && !owning[i] && d < bestd) begin
                     best = i;
                     bestd = d;
                  end
               end
               if (best >= 0) begin
                  m_lock[o] = 1'b1;
                  m_own[o]  = best;
               end
            end
         end
      end
   endtask

   task automatic compare_and_step();
      #1;
      model_outputs();
      for (int o = 0; o < 5; o++) check($sformatf("select%0d", o), 32'(sel_w[o]), 32'(exp_sel[o]));
      check("grant", 32'(gnt_w), 32'(exp_gnt));
      model_step();
   endtask

   initial begin
      rst = 1'b1;
      req = 5'b00000;
      tail = 5'b00000;
      ready = 5'b11111;
      for (int i = 0; i < 5; i++) dest[i] = 3'd0;
      model_reset();
      @(posedge clk);

      // The bench holds reset, then keeps the router idle after reset is released.
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         rst = (c < 2) ? 1'b1 : 1'b0;
         compare_and_step();
      end

      // L, N and W each send back-to-back single-flit packets to E.
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         req = 5'b10011;
         tail = 5'b11111;
         for (int i = 0; i < 5; i++) dest[i] = 3'd2;
         #1;
         for (int i = 0; i < 5; i++) if (gnt_w[i]) rr_order.push_back(i);
         compare_and_step();
      end
      check("rr_count", 32'(rr_order.size()), 32'd6);
      for (int k = 0; k < 6 && k < rr_order.size(); k++)
         check($sformatf("rr_order%0d", k), 32'(rr_order[k]), 32'((k % 3 == 2) ? 4 : k % 3));

      // The bench applies random traffic. Destinations are sticky, some are invalid, and reset is asserted occasionally.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 5; i++) begin
            req[i]   = ($urandom_range(0, 9) < 7);
            tail[i]  = ($urandom_range(0, 9) < 3);
            ready[i] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) begin
               int r = $urandom_range(0, 9);
               dest[i] = (r < 9) ? 3'(r % 5) : 3'(5 + $urandom_range(0, 2));
            end
         end
         compare_and_step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
